// File: rtl/hnf_pocq_pkg.sv
// hnf_pocq_pkg: shared types and defaults for the HN-F point-of-coherence queue.
// Provides the CHI request flit layout (reqflit_t), CHI field widths, request
// opcodes, and the default POCQ depth / maximum outstanding L-credit values.
package hnf_pocq_pkg;

    // CHI request flit field widths
    localparam int unsigned CHI_QOS_W    = 4;
    localparam int unsigned CHI_NODEID_W = 7;
    localparam int unsigned CHI_TXNID_W  = 8;
    localparam int unsigned CHI_OPCODE_W = 6;
    localparam int unsigned CHI_ADDR_W   = 44;

    // CHI request opcodes
    localparam logic [CHI_OPCODE_W-1:0] OPC_REQLCRDRETURN = 6'h00;
    localparam logic [CHI_OPCODE_W-1:0] OPC_READSHARED    = 6'h01;
    localparam logic [CHI_OPCODE_W-1:0] OPC_READCLEAN     = 6'h02;
    localparam logic [CHI_OPCODE_W-1:0] OPC_READUNIQUE    = 6'h07;
    localparam logic [CHI_OPCODE_W-1:0] OPC_WRITEBACKFULL = 6'h1B;

    // HN-F queue defaults
    localparam int unsigned HNF_POCQ_DEPTH = 8;
    localparam int unsigned HNF_MAX_LCRD   = 4;

    typedef struct packed {
        logic [CHI_QOS_W-1:0]    qos;
        logic [CHI_NODEID_W-1:0] srcid;
        logic [CHI_TXNID_W-1:0]  txnid;
        logic [CHI_OPCODE_W-1:0] opcode;
        logic [CHI_ADDR_W-1:0]   addr;
    } reqflit_t;

endpackage

// File: rtl/hnf_pocq_if.sv
// hnf_pocq_if: RXREQ channel plus the first-entry / pop handshake of the POCQ.
// slave  : the queue (accepts flits, grants credits, presents the oldest entry)
// master : the surrounding logic (requester side and downstream consumer)
interface hnf_pocq_if;
    import hnf_pocq_pkg::*;

    logic     rxreqflitv;
    reqflit_t rxreqflit;
    logic     rxreqlcrdv;
    reqflit_t rxreq_pocq_first_entry;
    logic     rxreq_pocq_first_entry_v;
    logic     pocq_pop;

    modport slave (
        input  rxreqflitv, rxreqflit, pocq_pop,
        output rxreqlcrdv, rxreq_pocq_first_entry, rxreq_pocq_first_entry_v
    );

    modport master (
        output rxreqflitv, rxreqflit, pocq_pop,
        input  rxreqlcrdv, rxreq_pocq_first_entry, rxreq_pocq_first_entry_v
    );
endinterface

// File: rtl/hnf_lcrd_ctrl.sv
// hnf_lcrd_ctrl: RXREQ L-credit counter and credit issue logic.
// Ports: clk, rst_n; rxreqflitv (incoming flit); count_next (queue occupancy
// after this edge); accept (flit is stored this cycle); rxreqlcrdv (registered
// credit pulse); lcrd_err (sticky flit-without-credit flag); lcrd_out (credits
// granted but not yet consumed).
module hnf_lcrd_ctrl
    import hnf_pocq_pkg::*;
#(
    parameter int unsigned POCQ_DEPTH = HNF_POCQ_DEPTH,
    parameter int unsigned MAX_LCRD   = HNF_MAX_LCRD,
    localparam int unsigned CNT_W     = $clog2(POCQ_DEPTH + 1),
    localparam int unsigned LCRD_W    = $clog2(MAX_LCRD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxreqflitv,
    input  logic [CNT_W-1:0]  count_next,
    output logic              accept,
    output logic              rxreqlcrdv,
    output logic              lcrd_err,
    output logic [LCRD_W-1:0] lcrd_out
);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [LCRD_W-1:0] lcrd_out_r;
    logic              lcrdv_r;
    logic              lcrd_err_r;
    logic              init_r;
    logic              accept_s;
    logic              issue_s;
    logic [LCRD_W-1:0] lcrd_cons_s;
    logic [LCRD_W-1:0] lcrd_next_s;
    logic [SUM_W-1:0]  reserved_s;

    // Credit decision: evaluated on post-update occupancy and credit count so
    // that occupancy plus outstanding credits never exceeds the queue depth.
    // init_r holds off the first grant by one cycle after reset release.
    always_comb begin
        accept_s    = rxreqflitv && (lcrd_out_r != LCRD_W'(0));
        lcrd_cons_s = lcrd_out_r - LCRD_W'(accept_s);
        reserved_s  = {1'b0, count_next} + SUM_W'(lcrd_cons_s);
        if (init_r && (lcrd_cons_s < LCRD_W'(MAX_LCRD)) && (reserved_s < SUM_W'(POCQ_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        lcrd_next_s = lcrd_cons_s + LCRD_W'(issue_s);
    end

    // Credit counter, registered grant pulse and sticky protocol error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcrd_out_r <= LCRD_W'(0);
            lcrdv_r    <= 1'b0;
            lcrd_err_r <= 1'b0;
            init_r     <= 1'b0;
        end else begin
            init_r     <= 1'b1;
            lcrd_out_r <= lcrd_next_s;
            lcrdv_r    <= issue_s;
            if (rxreqflitv && (lcrd_out_r == LCRD_W'(0))) begin
                lcrd_err_r <= 1'b1;
            end else begin
                lcrd_err_r <= lcrd_err_r;
            end
        end
    end

    assign accept     = accept_s;
    assign rxreqlcrdv = lcrdv_r;
    assign lcrd_err   = lcrd_err_r;
    assign lcrd_out   = lcrd_out_r;
endmodule

// File: rtl/hnf_pocq_chk.sv
// hnf_pocq_chk: assertion checker for the POCQ.
// Ports: clk, rst_n; wr_en (entry written this cycle); full (queue full);
// count (occupancy).
module hnf_pocq_chk #(
    parameter int unsigned POCQ_DEPTH = 8,
    localparam int unsigned CNT_W     = $clog2(POCQ_DEPTH + 1)
) (
    input logic             clk,
    input logic             rst_n,
    input logic             wr_en,
    input logic             full,
    input logic [CNT_W-1:0] count
);
    // A write into a full queue means the credit scheme was violated.
    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

    // Occupancy must stay within the physical depth.
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_W'(POCQ_DEPTH));
endmodule

// File: rtl/hnf_pocq.sv
// hnf_pocq: HN-F point-of-coherence request queue (circular buffer).
// Ports: clk, rst_n; bus (hnf_pocq_if.slave: RXREQ flit in, L-credit out,
// oldest entry + valid out, pop in); pocq_count, pocq_full, pocq_empty
// (occupancy status); lcrd_err (sticky flit-without-credit flag).
module hnf_pocq
    import hnf_pocq_pkg::*;
#(
    parameter int unsigned POCQ_DEPTH = HNF_POCQ_DEPTH,
    parameter int unsigned MAX_LCRD   = HNF_MAX_LCRD
) (
    input  logic                              clk,
    input  logic                              rst_n,
    hnf_pocq_if.slave                         bus,
    output logic [$clog2(POCQ_DEPTH+1)-1:0]   pocq_count,
    output logic                              pocq_full,
    output logic                              pocq_empty,
    output logic                              lcrd_err
);
    localparam int unsigned PTR_W  = $clog2(POCQ_DEPTH);
    localparam int unsigned CNT_W  = $clog2(POCQ_DEPTH + 1);
    localparam int unsigned LCRD_W = $clog2(MAX_LCRD + 1);

    reqflit_t          mem_r [POCQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_r;
    logic              empty_r;
    logic              first_v_r;
    reqflit_t          first_r;

    logic              accept_s;
    logic              pop_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [CNT_W-1:0]  count_next_s;
    reqflit_t          first_next_s;
    logic              lcrdv_s;
    logic              lcrd_err_s;
    logic [LCRD_W-1:0] lcrd_out_s;

    hnf_lcrd_ctrl #(
        .POCQ_DEPTH (POCQ_DEPTH),
        .MAX_LCRD   (MAX_LCRD)
    ) u_lcrd_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxreqflitv (bus.rxreqflitv),
        .count_next (count_next_s),
        .accept     (accept_s),
        .rxreqlcrdv (lcrdv_s),
        .lcrd_err   (lcrd_err_s),
        .lcrd_out   (lcrd_out_s)
    );

    hnf_pocq_chk #(
        .POCQ_DEPTH (POCQ_DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (accept_s),
        .full  (full_r),
        .count (count_r)
    );

    // Next occupancy, next read pointer and the entry that will be oldest after
    // this edge. A push lands on the oldest slot only when the queue drains to
    // that slot this cycle, in which case the incoming flit is forwarded.
    always_comb begin
        pop_s = bus.pocq_pop && first_v_r;
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (accept_s && (rd_ptr_next_s == wr_ptr_r)) begin
            first_next_s = bus.rxreqflit;
        end else begin
            first_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Entry storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= bus.rxreqflit;
        end
    end

    // Pointers, occupancy and registered status / first-entry outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= PTR_W'(0);
            rd_ptr_r  <= PTR_W'(0);
            count_r   <= CNT_W'(0);
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            first_v_r <= 1'b0;
            first_r   <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r  <= rd_ptr_next_s;
            count_r   <= count_next_s;
            full_r    <= (count_next_s == CNT_W'(POCQ_DEPTH));
            empty_r   <= (count_next_s == CNT_W'(0));
            first_v_r <= (count_next_s != CNT_W'(0));
            first_r   <= first_next_s;
        end
    end

    assign bus.rxreqlcrdv               = lcrdv_s;
    assign bus.rxreq_pocq_first_entry   = first_r;
    assign bus.rxreq_pocq_first_entry_v = first_v_r;
    assign pocq_count                   = count_r;
    assign pocq_full                    = full_r;
    assign pocq_empty                   = empty_r;
    assign lcrd_err                     = lcrd_err_s;

    // lcrd_out is consumed inside the credit controller; kept visible here for debug.
    logic lcrd_out_unused_s;
    assign lcrd_out_unused_s = ^lcrd_out_s;
endmodule

// File: tb/tb_hnf_pocq.sv
// tb_hnf_pocq: self-checking bench for hnf_pocq (DEPTH=8, MAX_LCRD=4).
// Directed table after reset, fill/error/drain sequences, then randomized
// push/pop traffic with a mid-stream reset, all checked against a queue model.
module tb_hnf_pocq;
    import hnf_pocq_pkg::*;

    localparam int DEPTH = 8;
    localparam int MAXC  = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] pocq_count;
    logic       pocq_full;
    logic       pocq_empty;
    logic       lcrd_err;

    hnf_pocq_if bus_if ();

    hnf_pocq #(
        .POCQ_DEPTH (DEPTH),
        .MAX_LCRD   (MAXC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .pocq_count (pocq_count),
        .pocq_full  (pocq_full),
        .pocq_empty (pocq_empty),
        .lcrd_err   (lcrd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the queue contents, credits the requester holds, error flag.
    reqflit_t mq[$];
    int       m_lcrd;
    bit       m_err;
    bit       m_lcrdv;
    int       m_edges;

    typedef struct {
        bit          flitv;
        bit          pop;
        logic [43:0] addr;
        int          exp_count;
        bit          exp_lcrdv;
        bit          exp_v;
        logic [43:0] exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic reqflit_t mk_flit(input logic [43:0] addr);
        reqflit_t f;
        logic [95:0] rnd;
        rnd = {$urandom(), $urandom(), $urandom()};
        f = rnd[$bits(reqflit_t)-1:0];
        f.opcode = OPC_READSHARED;
        f.addr = addr;
        return f;
    endfunction

    // Predicts the effect of the coming clock edge.
    task automatic model_edge(input bit fv, input bit pp, input reqflit_t f);
        bit acc;
        bit popok;
        int held;
        acc = fv && (m_lcrd > 0);
        if (fv && !acc) m_err = 1'b1;
        popok = pp && (mq.size() > 0);
        if (popok) void'(mq.pop_front());
        if (acc) mq.push_back(f);
        held = m_lcrd - (acc ? 1 : 0);
        m_lcrdv = (m_edges >= 1) && (held < MAXC) && (mq.size() + held < DEPTH);
        m_lcrd = held + (m_lcrdv ? 1 : 0);
        m_edges++;
    endtask

    task automatic check_model();
        chk("count", 128'(pocq_count), 128'(mq.size()));
        chk("first_v", 128'(bus_if.rxreq_pocq_first_entry_v), 128'(mq.size() != 0));
        chk("empty", 128'(pocq_empty), 128'(mq.size() == 0));
        chk("full", 128'(pocq_full), 128'(mq.size() == DEPTH));
        chk("lcrdv", 128'(bus_if.rxreqlcrdv), 128'(m_lcrdv));
        chk("lcrd_err", 128'(lcrd_err), 128'(m_err));
        if (mq.size() > 0) chk("first_entry", 128'(bus_if.rxreq_pocq_first_entry), 128'(mq[0]));
    endtask

    task automatic cycle(input bit fv, input bit pp, input reqflit_t f);
        bus_if.rxreqflitv = fv;
        bus_if.rxreqflit  = f;
        bus_if.pocq_pop   = pp;
        model_edge(fv, pp, f);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.rxreqflitv = 1'b0;
        bus_if.pocq_pop   = 1'b0;
        #1;
        chk("rst_count", 128'(pocq_count), 128'(0));
        chk("rst_first_v", 128'(bus_if.rxreq_pocq_first_entry_v), 128'(0));
        chk("rst_empty", 128'(pocq_empty), 128'(1));
        chk("rst_full", 128'(pocq_full), 128'(0));
        chk("rst_lcrdv", 128'(bus_if.rxreqlcrdv), 128'(0));
        chk("rst_lcrd_err", 128'(lcrd_err), 128'(0));
        mq.delete();
        m_lcrd = 0; m_err = 1'b0; m_lcrdv = 1'b0; m_edges = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[16];

    initial begin
        int pushed;
        int naddr;
        bit fv;
        bit pp;
        rst_n = 1'b0;
        bus_if.rxreqflitv = 1'b0;
        bus_if.rxreqflit  = '0;
        bus_if.pocq_pop   = 1'b0;

        // Credits ramp, FIFO order, single-entry push+pop.
        vecs[0]  = '{0, 0, 44'h0,   0, 0, 0, 44'h0};
        vecs[1]  = '{0, 0, 44'h0,   0, 1, 0, 44'h0};
        vecs[2]  = '{0, 0, 44'h0,   0, 1, 0, 44'h0};
        vecs[3]  = '{0, 0, 44'h0,   0, 1, 0, 44'h0};
        vecs[4]  = '{0, 0, 44'h0,   0, 1, 0, 44'h0};
        vecs[5]  = '{0, 0, 44'h0,   0, 0, 0, 44'h0};
        vecs[6]  = '{0, 0, 44'h0,   0, 0, 0, 44'h0};
        vecs[7]  = '{1, 0, 44'h100, 1, 1, 1, 44'h100};
        vecs[8]  = '{1, 0, 44'h140, 2, 1, 1, 44'h100};
        vecs[9]  = '{1, 0, 44'h180, 3, 1, 1, 44'h100};
        vecs[10] = '{0, 1, 44'h0,   2, 0, 1, 44'h140};
        vecs[11] = '{0, 1, 44'h0,   1, 0, 1, 44'h180};
        vecs[12] = '{0, 1, 44'h0,   0, 0, 0, 44'h0};
        vecs[13] = '{1, 0, 44'h200, 1, 1, 1, 44'h200};
        vecs[14] = '{1, 1, 44'h240, 1, 1, 1, 44'h240};
        vecs[15] = '{0, 1, 44'h0,   0, 0, 0, 44'h0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].flitv, vecs[i].pop, mk_flit(vecs[i].addr));
            chk($sformatf("vec%0d_count", i), 128'(pocq_count), 128'(vecs[i].exp_count));
            chk($sformatf("vec%0d_lcrdv", i), 128'(bus_if.rxreqlcrdv), 128'(vecs[i].exp_lcrdv));
            chk($sformatf("vec%0d_v", i), 128'(bus_if.rxreq_pocq_first_entry_v), 128'(vecs[i].exp_v));
            chk($sformatf("vec%0d_empty", i), 128'(pocq_empty), 128'(!vecs[i].exp_v));
            if (vecs[i].exp_v)
                chk($sformatf("vec%0d_addr", i), 128'(bus_if.rxreq_pocq_first_entry.addr), 128'(vecs[i].exp_addr));
        end

        // Fill to full using only granted credits, then idle: no further credit.
        pushed = 0;
        for (int i = 0; i < 40 && pushed < DEPTH; i++) begin
            fv = (m_lcrd > 0);
            cycle(fv, 1'b0, mk_flit(44'h1000 + 44'(i) * 44'h40));
            if (fv) pushed++;
        end
        chk("fill_count", 128'(pocq_count), 128'(DEPTH));
        chk("fill_full", 128'(pocq_full), 128'(1));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, mk_flit(44'h0));
            chk("full_no_credit", 128'(bus_if.rxreqlcrdv), 128'(0));
        end

        // Flit without any outstanding credit is dropped and flagged.
        cycle(1'b1, 1'b0, mk_flit(44'hBAD));
        chk("drop_count", 128'(pocq_count), 128'(DEPTH));
        chk("drop_err", 128'(lcrd_err), 128'(1));

        // Drain.
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b1, mk_flit(44'h0));

        // Randomized push/pop stream, reset in the middle.
        do_reset();
        naddr = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                chk("midrst_count", 128'(pocq_count), 128'(0));
                chk("midrst_v", 128'(bus_if.rxreq_pocq_first_entry_v), 128'(0));
            end
            fv = (m_lcrd > 0) && ($urandom_range(0, 3) != 0);
            pp = ($urandom_range(0, 2) != 0);
            cycle(fv, pp, mk_flit(44'h4000 + 44'(naddr) * 44'h40));
            if (fv) naddr++;
        end
        chk("stream_progress", 128'(naddr > 40), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
